// File: rtl/encoder_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : encoder_sequencer
//  Purpose  : Round/step scheduler for the encoder datapath. Runs the five
//             per-round step units (0 colParity, 1 rotate, 2 permute,
//             3 revaluate, 4 addRC) in fixed order for ROUNDS rounds. Each
//             step unit is driven through a start/ready handshake. The block
//             also drives the ping-pong state-memory select and the round
//             index that addRC uses.
//  Ports    : clk        - clock, rising edge
//             rst        - asynchronous active-low reset
//             start      - encode request (level), sampled only in IDLE
//             step_ready - per-unit 1-cycle done pulses
//             step_start - per-unit start, one-hot or zero
//             round_idx  - current round, 0..ROUNDS-1
//             mem_sel    - 0: read MEM_A / write MEM_B, 1: the reverse
//             busy       - high in every state except IDLE
//             ready      - 1-cycle pulse when an encode completes
//             err        - sticky watchdog error, cleared by the next start
//  Revision : 1.0 - initial release
// ============================================================================
module encoder_sequencer #(
  parameter int ROUNDS  = 24,
  parameter int RW      = 5,
  parameter int TIMEOUT = 4096,
  parameter int TW      = 12
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [4:0]    step_ready,
  output logic [4:0]    step_start,
  output logic [RW-1:0] round_idx,
  output logic          mem_sel,
  output logic          busy,
  output logic          ready,
  output logic          err
);

  localparam logic [2:0] c_st_idle      = 3'd0;
  localparam logic [2:0] c_st_wait_rel  = 3'd1;
  localparam logic [2:0] c_st_launch    = 3'd2;
  localparam logic [2:0] c_st_wait_step = 3'd3;
  localparam logic [2:0] c_st_next      = 3'd4;
  localparam logic [2:0] c_st_done      = 3'd5;

  localparam logic [2:0]    c_last_step  = 3'd4;
  localparam logic [RW-1:0] c_last_round = RW'(ROUNDS - 1);
  localparam logic [TW-1:0] c_wdog_limit = TW'(TIMEOUT - 1);

  logic [2:0]    state_q, state_d;
  logic [2:0]    step_q, step_d;
  logic [RW-1:0] round_q, round_d;
  logic          mem_sel_q, mem_sel_d;
  logic          err_q, err_d;
  logic [TW-1:0] wdog_q, wdog_d;

  logic [4:0]    w_step_onehot;
  logic          w_ready_hit;

  // One-hot of the current step; codes 5..7 cannot occur but decode to zero
  // so a corrupted step can never start a unit or be acknowledged.
  always_comb begin
    w_step_onehot = 5'b00000;
    case (step_q)
      3'd0:    w_step_onehot = 5'b00001;
      3'd1:    w_step_onehot = 5'b00010;
      3'd2:    w_step_onehot = 5'b00100;
      3'd3:    w_step_onehot = 5'b01000;
      3'd4:    w_step_onehot = 5'b10000;
      default: w_step_onehot = 5'b00000;
    endcase
  end

  // Only the ready bit of the unit currently being waited on matters.
  assign w_ready_hit = |(step_ready & w_step_onehot);

  always_comb begin
    state_d   = state_q;
    step_d    = step_q;
    round_d   = round_q;
    mem_sel_d = mem_sel_q;
    err_d     = err_q;
    wdog_d    = wdog_q;
    case (state_q)
      c_st_idle: begin
        if (start) begin
          state_d   = c_st_wait_rel;
          step_d    = 3'd0;
          round_d   = '0;
          mem_sel_d = 1'b0;
          err_d     = 1'b0;
          wdog_d    = '0;
        end
      end
      c_st_wait_rel: begin
        if (!start) begin
          state_d = c_st_launch;
        end
      end
      c_st_launch: begin
        wdog_d  = '0;
        state_d = c_st_wait_step;
      end
      c_st_wait_step: begin
        if (w_ready_hit) begin
          state_d = c_st_next;
        end else begin
          wdog_d = wdog_q + TW'(1);
          // wdog counts WAIT_STEP cycles already spent, so the TIMEOUT-th
          // unanswered cycle is the one where it reads TIMEOUT-1.
          if (wdog_q == c_wdog_limit) begin
            err_d   = 1'b1;
            state_d = c_st_idle;
          end
        end
      end
      c_st_next: begin
        mem_sel_d = ~mem_sel_q;
        if (step_q < c_last_step) begin
          step_d  = step_q + 3'd1;
          state_d = c_st_launch;
        end else if (round_q < c_last_round) begin
          step_d  = 3'd0;
          round_d = round_q + RW'(1);
          state_d = c_st_launch;
        end else begin
          step_d  = 3'd0;
          state_d = c_st_done;
        end
      end
      c_st_done: begin
        state_d = c_st_idle;
      end
      default: begin
        state_d = c_st_idle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= c_st_idle;
      step_q    <= 3'd0;
      round_q   <= '0;
      mem_sel_q <= 1'b0;
      err_q     <= 1'b0;
      wdog_q    <= '0;
    end else begin
      state_q   <= state_d;
      step_q    <= step_d;
      round_q   <= round_d;
      mem_sel_q <= mem_sel_d;
      err_q     <= err_d;
      wdog_q    <= wdog_d;
    end
  end

  assign step_start = (state_q == c_st_launch) ? w_step_onehot : 5'b00000;
  assign busy       = (state_q != c_st_idle);
  assign ready      = (state_q == c_st_done);
  assign round_idx  = round_q;
  assign mem_sel    = mem_sel_q;
  assign err        = err_q;

endmodule
`default_nettype wire

// File: tb/tb_encoder_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_encoder_sequencer
//  Purpose  : Directed self-checking bench for encoder_sequencer. Step units
//             are stubbed to answer 3 cycles after their start (k = 3), so a
//             full encode is 1 + 120*5 + 1 = 602 cycles counted from the
//             WAIT_REL cycle in which start is low.
//  Ports    : none
//  Revision : 1.0 - initial release
// ============================================================================
module tb_encoder_sequencer;

  localparam int ROUNDS  = 24;
  localparam int RW      = 5;
  localparam int TIMEOUT = 16;
  localparam int TW      = 12;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [4:0]    step_ready;
  logic [4:0]    step_start;
  logic [RW-1:0] round_idx;
  logic          mem_sel;
  logic          busy;
  logic          ready;
  logic          err;

  logic [4:0]    stub_ready;
  logic [4:0]    man_ready;
  assign step_ready = stub_ready | man_ready;

  int n_cmp = 0;
  int n_bad = 0;

  encoder_sequencer #(
    .ROUNDS  (ROUNDS),
    .RW      (RW),
    .TIMEOUT (TIMEOUT),
    .TW      (TW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .step_ready (step_ready),
    .step_start (step_start),
    .round_idx  (round_idx),
    .mem_sel    (mem_sel),
    .busy       (busy),
    .ready      (ready),
    .err        (err)
  );

  always #5 clk = ~clk;

  // Step-unit stubs: answer 3 cycles after the start pulse, unless muted.
  bit         stub_en = 1'b1;
  logic [4:0] stub_mute = 5'b00000;
  int         stub_cnt = 0;
  int         stub_unit = 0;
  always @(negedge clk) begin
    stub_ready = 5'b00000;
    if (!rst || !busy) begin
      stub_cnt = 0;
    end else begin
      if (stub_cnt > 0) begin
        stub_cnt--;
        if (stub_cnt == 0) stub_ready[stub_unit] = 1'b1;
      end
      if (stub_en && step_start != 5'b00000) begin
        for (int i = 0; i < 5; i++) begin
          if (step_start[i] && !stub_mute[i]) begin
            stub_unit = i;
            stub_cnt  = 3;
          end
        end
      end
    end
  end

  // Independent model of the launch order: pulse p must start unit p%5 in
  // round p/5 with mem_sel = p%2 (one toggle per completed step).
  int mon_pulses = 0;
  int mon_viol   = 0;
  always @(negedge clk) begin
    if (!rst || !busy) begin
      mon_pulses = 0;
    end else if (step_start != 5'b00000) begin
      if (step_start !== (5'b00001 << (mon_pulses % 5)) ||
          round_idx !== RW'(mon_pulses / 5) ||
          mem_sel !== mon_pulses[0])
        mon_viol++;
      mon_pulses++;
    end
  end

  task automatic begin_encode();
    start = 1'b1;
    @(negedge clk);
  endtask

  task automatic finish_encode(output int cyc, output bit got);
    start = 1'b0;
    cyc   = 1;
    got   = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      cyc++;
      if (ready === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_cmp++;
    if ({step_start, round_idx, mem_sel, busy, ready, err} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: got %b want all zero",
               {step_start, round_idx, mem_sel, busy, ready, err});
    end
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0 || step_start !== 5'b00000) begin
      n_bad++;
      $display("FAIL idle_hold: busy=%b step_start=%b want 0/00000", busy, step_start);
    end
  endtask

  task automatic test_full_run();
    int cyc;
    bit got;
    int v0;
    stub_en = 1'b1;
    stub_mute = 5'b00000;
    v0 = mon_viol;
    begin_encode();
    finish_encode(cyc, got);
    n_cmp++;
    if (got !== 1'b1) begin n_bad++; $display("FAIL full_ready_seen: got %b want 1", got); end
    n_cmp++;
    if (cyc !== 602) begin n_bad++; $display("FAIL full_latency: got %0d want 602", cyc); end
    n_cmp++;
    if (mon_pulses !== 120) begin n_bad++; $display("FAIL full_pulses: got %0d want 120", mon_pulses); end
    n_cmp++;
    if (mon_viol - v0 !== 0) begin n_bad++; $display("FAIL full_order: got %0d violations want 0", mon_viol - v0); end
    n_cmp++;
    if (mem_sel !== 1'b0 || err !== 1'b0) begin
      n_bad++; $display("FAIL full_end_flags: mem_sel=%b err=%b want 0/0", mem_sel, err);
    end
    n_cmp++;
    if (round_idx !== RW'(23)) begin n_bad++; $display("FAIL full_last_round: got %0d want 23", round_idx); end
    @(negedge clk);
    n_cmp++;
    if (ready !== 1'b0 || busy !== 1'b0) begin
      n_bad++; $display("FAIL full_after_done: ready=%b busy=%b want 0/0", ready, busy);
    end
  endtask

  task automatic test_start_hold();
    int cyc;
    bit got;
    begin_encode();
    for (int i = 0; i < 10; i++) begin
      n_cmp++;
      if (busy !== 1'b1 || step_start !== 5'b00000) begin
        n_bad++;
        $display("FAIL hold_cycle%0d: busy=%b step_start=%b want 1/00000", i, busy, step_start);
      end
      @(negedge clk);
    end
    start = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (step_start !== 5'b00001) begin
      n_bad++; $display("FAIL hold_first_launch: got %b want 00001", step_start);
    end
    finish_encode(cyc, got);
    n_cmp++;
    if (got !== 1'b1 || cyc !== 601) begin
      n_bad++; $display("FAIL hold_complete: got ready=%b cyc=%0d want 1/601", got, cyc);
    end
    @(negedge clk);
  endtask

  task automatic test_stray_ready();
    stub_en = 1'b0;
    man_ready = 5'b00000;
    begin_encode();
    start = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (step_start !== 5'b00001) begin n_bad++; $display("FAIL stray_launch0: got %b want 00001", step_start); end
    @(negedge clk);
    man_ready = 5'b00001;
    @(negedge clk);
    man_ready = 5'b00000;
    @(negedge clk);
    n_cmp++;
    if (step_start !== 5'b00010 || mem_sel !== 1'b1) begin
      n_bad++; $display("FAIL stray_launch1: step_start=%b mem_sel=%b want 00010/1", step_start, mem_sel);
    end
    @(negedge clk);
    man_ready = 5'b01000;
    @(negedge clk);
    man_ready = 5'b00000;
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if (busy !== 1'b1 || step_start !== 5'b00000) begin
        n_bad++;
        $display("FAIL stray_no_advance%0d: busy=%b step_start=%b want 1/00000", i, busy, step_start);
      end
      if (i < 4) @(negedge clk);
    end
    man_ready = 5'b00010;
    @(negedge clk);
    man_ready = 5'b00000;
    n_cmp++;
    if (step_start !== 5'b00000) begin n_bad++; $display("FAIL stray_next: got %b want 00000", step_start); end
    @(negedge clk);
    n_cmp++;
    if (step_start !== 5'b00100 || mem_sel !== 1'b0 || err !== 1'b0) begin
      n_bad++;
      $display("FAIL stray_launch2: step_start=%b mem_sel=%b err=%b want 00100/0/0", step_start, mem_sel, err);
    end
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    stub_en = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_timeout();
    int cyc;
    bit got;
    bit found;
    stub_en = 1'b1;
    stub_mute = 5'b00100;
    begin_encode();
    start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (step_start === 5'b00100) begin
        found = 1'b1;
        break;
      end
    end
    n_cmp++;
    if (found !== 1'b1) begin n_bad++; $display("FAIL to_find_step2: got %b want 1", found); end
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      n_cmp++;
      if (busy !== 1'b1 || err !== 1'b0 || ready !== 1'b0) begin
        n_bad++;
        $display("FAIL to_wait%0d: busy=%b err=%b ready=%b want 1/0/0", i, busy, err, ready);
      end
    end
    @(negedge clk);
    n_cmp++;
    if (err !== 1'b1 || busy !== 1'b0 || ready !== 1'b0) begin
      n_bad++; $display("FAIL to_expired: err=%b busy=%b ready=%b want 1/0/0", err, busy, ready);
    end
    repeat (3) @(negedge clk);
    n_cmp++;
    if (err !== 1'b1 || ready !== 1'b0) begin
      n_bad++; $display("FAIL to_sticky: err=%b ready=%b want 1/0", err, ready);
    end
    stub_mute = 5'b00000;
    begin_encode();
    n_cmp++;
    if (err !== 1'b0 || busy !== 1'b1) begin
      n_bad++; $display("FAIL to_err_clear: err=%b busy=%b want 0/1", err, busy);
    end
    finish_encode(cyc, got);
    n_cmp++;
    if (got !== 1'b1 || cyc !== 602 || err !== 1'b0) begin
      n_bad++; $display("FAIL to_rerun: ready=%b cyc=%0d err=%b want 1/602/0", got, cyc, err);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_run();
    int cyc;
    bit got;
    bit found;
    int v0;
    begin_encode();
    start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (step_start === 5'b01000 && round_idx === RW'(5)) begin
        found = 1'b1;
        break;
      end
    end
    n_cmp++;
    if (found !== 1'b1) begin n_bad++; $display("FAIL rst_find_r5s3: got %b want 1", found); end
    rst = 1'b0;
    #1;
    n_cmp++;
    if ({step_start, round_idx, mem_sel, busy, ready, err} !== '0) begin
      n_bad++;
      $display("FAIL rst_async_clear: got %b want all zero",
               {step_start, round_idx, mem_sel, busy, ready, err});
    end
    repeat (2) @(negedge clk);
    n_cmp++;
    if (ready !== 1'b0 || busy !== 1'b0) begin
      n_bad++; $display("FAIL rst_held: ready=%b busy=%b want 0/0", ready, busy);
    end
    rst = 1'b1;
    @(negedge clk);
    v0 = mon_viol;
    begin_encode();
    finish_encode(cyc, got);
    n_cmp++;
    if (got !== 1'b1 || cyc !== 602) begin
      n_bad++; $display("FAIL rst_clean_run: ready=%b cyc=%0d want 1/602", got, cyc);
    end
    n_cmp++;
    if (mon_pulses !== 120 || mon_viol - v0 !== 0 || mem_sel !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_clean_order: pulses=%0d viol=%0d mem_sel=%b want 120/0/0",
               mon_pulses, mon_viol - v0, mem_sel);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int cyc;
    bit got;
    int v0;
    begin_encode();
    finish_encode(cyc, got);
    n_cmp++;
    if (got !== 1'b1) begin n_bad++; $display("FAIL b2b_first_ready: got %b want 1", got); end
    start = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0 || ready !== 1'b0) begin
      n_bad++; $display("FAIL b2b_idle: busy=%b ready=%b want 0/0", busy, ready);
    end
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b1 || round_idx !== RW'(0) || mem_sel !== 1'b0 || err !== 1'b0) begin
      n_bad++;
      $display("FAIL b2b_restart: busy=%b round_idx=%0d mem_sel=%b err=%b want 1/0/0/0",
               busy, round_idx, mem_sel, err);
    end
    v0 = mon_viol;
    finish_encode(cyc, got);
    n_cmp++;
    if (got !== 1'b1 || cyc !== 602) begin
      n_bad++; $display("FAIL b2b_second_run: ready=%b cyc=%0d want 1/602", got, cyc);
    end
    n_cmp++;
    if (mon_pulses !== 120 || mon_viol - v0 !== 0) begin
      n_bad++; $display("FAIL b2b_order: pulses=%0d viol=%0d want 120/0", mon_pulses, mon_viol - v0);
    end
    @(negedge clk);
  endtask

  initial begin
    rst       = 1'b0;
    start     = 1'b0;
    man_ready = 5'b00000;
    test_reset();
    test_full_run();
    test_start_hold();
    test_stray_ready();
    test_timeout();
    test_reset_mid_run();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL global_timeout: simulation did not finish, want completion");
    $fatal(1, "global timeout");
  end

endmodule
`default_nettype wire
